// File: rtl/rvga_types.sv
// Shared pipeline types: load/store opcodes (also used by decode and the debug bus)
// and the memory-stage access state.
package rvga_types;
  localparam int RVGA_WORD = 32;
  localparam int RVGA_REG  = 5;

  typedef enum logic [2:0] {LDNONE, LB, LH, LW, LBU, LHU} rvga_ldop_e;
  typedef enum logic [1:0] {STNONE, SB, SH, SW} rvga_strop_e;
  typedef enum logic {IDLE, WAIT_RESP} rvga_memstate_e;
endpackage

// File: rtl/memory_stage_load_align.sv
// Load lane select and sign/zero extension; purely combinational.
module load_align
  import rvga_types::*;
(
  input  logic [RVGA_WORD-1:0] resp_data,
  input  logic [1:0]           addr_lo,
  input  rvga_ldop_e           ldop,
  output logic [RVGA_WORD-1:0] data
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Halves only look at addr_lo[1]: a stray addr_lo[0] never shifts the lane.
  assign byte_sel = resp_data[{addr_lo, 3'b000} +: 8];
  assign half_sel = addr_lo[1] ? resp_data[31:16] : resp_data[15:0];

  always_comb begin
    data = '0;
    case (ldop)
      LB:      data = {{24{byte_sel[7]}}, byte_sel};
      LBU:     data = {24'h0, byte_sel};
      LH:      data = {{16{half_sel[15]}}, half_sel};
      LHU:     data = {16'h0, half_sel};
      LW:      data = resp_data;
      default: data = '0;
    endcase
  end
endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: registers ALU results, runs loads/stores over a valid/ready
// data port. Define MEMORY_STAGE_MISALIGN_CHECK_EN to trap misaligned half/word accesses.
module memory_stage
  import rvga_types::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 execute_memory_v,
  input  logic [RVGA_REG-1:0]  execute_memory_rs1,
  input  logic [RVGA_REG-1:0]  execute_memory_rs2,
  input  logic [RVGA_REG-1:0]  execute_memory_rd,
  input  logic                 execute_memory_rd_w_v,
  input  logic [RVGA_WORD-1:0] execute_memory_result,
  input  logic [RVGA_WORD-1:0] execute_memory_store_data,
  input  rvga_ldop_e           execute_memory_ldop,
  input  rvga_strop_e          execute_memory_strop,
  output logic                 memory_stall,
  output logic                 dmem_req_v,
  input  logic                 dmem_req_ready,
  output logic [RVGA_WORD-1:0] dmem_addr,
  output logic                 dmem_w_v,
  output logic [RVGA_WORD-1:0] dmem_wdata,
  output logic [3:0]           dmem_wmask,
  input  logic                 dmem_resp_v,
  input  logic [RVGA_WORD-1:0] dmem_resp_data,
  output logic                 memory_writeback_v,
  output logic [RVGA_REG-1:0]  memory_writeback_rd,
  output logic                 memory_writeback_rd_w_v,
  output logic [RVGA_WORD-1:0] memory_writeback_data,
  output logic                 memory_misaligned
);
  rvga_memstate_e       state_q, state_d;
  logic                 wb_v_q, wb_v_d, wb_rd_w_v_q, wb_rd_w_v_d, mis_q, mis_d;
  logic [RVGA_REG-1:0]  wb_rd_q, wb_rd_d;
  logic [RVGA_WORD-1:0] wb_data_q, wb_data_d, load_word;
  logic [1:0]           lane;
  logic                 is_load, is_store, misalign;
  logic                 unused_ok;

  assign lane      = execute_memory_result[1:0];
  assign is_load   = execute_memory_ldop != LDNONE;
  assign is_store  = !is_load && execute_memory_strop != STNONE;
  assign unused_ok = ^{execute_memory_rs1, execute_memory_rs2};

  load_align u_load_align (
    .resp_data (dmem_resp_data),
    .addr_lo   (lane),
    .ldop      (execute_memory_ldop),
    .data      (load_word)
  );

  always_comb begin
    misalign = 1'b0;
`ifdef MEMORY_STAGE_MISALIGN_CHECK_EN
    if (is_load) begin
      if (execute_memory_ldop == LH || execute_memory_ldop == LHU) misalign = lane[0];
      else if (execute_memory_ldop == LW)                          misalign = |lane;
    end else if (is_store) begin
      if (execute_memory_strop == SH)      misalign = lane[0];
      else if (execute_memory_strop == SW) misalign = |lane;
    end
`endif
  end

  always_comb begin
    state_d      = state_q;
    wb_v_d       = 1'b0;
    wb_rd_d      = wb_rd_q;
    wb_rd_w_v_d  = wb_rd_w_v_q;
    wb_data_d    = wb_data_q;
    mis_d        = 1'b0;
    memory_stall = 1'b0;
    dmem_req_v   = 1'b0;
    dmem_w_v     = 1'b0;
    dmem_addr    = {execute_memory_result[31:2], 2'b00};
    dmem_wdata   = '0;
    dmem_wmask   = 4'b0000;
    case (state_q)
      IDLE: if (execute_memory_v) begin
        if (misalign) begin
          mis_d       = 1'b1;
          wb_v_d      = 1'b1;
          wb_rd_d     = execute_memory_rd;
          wb_rd_w_v_d = 1'b0;
          wb_data_d   = execute_memory_result;
        end else if (is_load) begin
          dmem_req_v   = 1'b1;
          memory_stall = 1'b1;
          if (dmem_req_ready) state_d = WAIT_RESP;
        end else if (is_store) begin
          dmem_req_v   = 1'b1;
          dmem_w_v     = 1'b1;
          memory_stall = !dmem_req_ready;
          case (execute_memory_strop)
            SB: begin
              dmem_wmask = 4'b0001 << lane;
              dmem_wdata = {4{execute_memory_store_data[7:0]}};
            end
            SH: begin
              dmem_wmask = 4'b0011 << {lane[1], 1'b0};
              dmem_wdata = {2{execute_memory_store_data[15:0]}};
            end
            default: begin
              dmem_wmask = 4'b1111;
              dmem_wdata = execute_memory_store_data;
            end
          endcase
          if (dmem_req_ready) begin
            wb_v_d      = 1'b1;
            wb_rd_d     = execute_memory_rd;
            wb_rd_w_v_d = 1'b0;
            wb_data_d   = execute_memory_result;
          end
        end else begin
          wb_v_d      = 1'b1;
          wb_rd_d     = execute_memory_rd;
          wb_rd_w_v_d = execute_memory_rd_w_v;
          wb_data_d   = execute_memory_result;
        end
      end
      WAIT_RESP: begin
        // Upstream is held while we wait, so the rd/ldop inputs still describe this load.
        memory_stall = !dmem_resp_v;
        if (dmem_resp_v) begin
          wb_v_d      = 1'b1;
          wb_rd_d     = execute_memory_rd;
          wb_rd_w_v_d = execute_memory_rd_w_v;
          wb_data_d   = load_word;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wb_v_q      <= 1'b0;
      wb_rd_q     <= '0;
      wb_rd_w_v_q <= 1'b0;
      wb_data_q   <= '0;
      mis_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wb_v_q      <= wb_v_d;
      wb_rd_q     <= wb_rd_d;
      wb_rd_w_v_q <= wb_rd_w_v_d;
      wb_data_q   <= wb_data_d;
      mis_q       <= mis_d;
    end
  end

  assign memory_writeback_v      = wb_v_q;
  assign memory_writeback_rd     = wb_rd_q;
  assign memory_writeback_rd_w_v = wb_rd_w_v_q;
  assign memory_writeback_data   = wb_data_q;
  assign memory_misaligned       = mis_q;
endmodule
